// File: rtl/track_junction_arbiter.sv
// Round-robin arbiter for one shared track junction: grants one train at a time,
// follows the occupancy sensor through entry, exit and a guard interval, and flags misuse.
module track_junction_arbiter #(
  parameter int N_TRAINS       = 4,
  parameter int CLEAR_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int IDW           = (N_TRAINS > 1) ? $clog2(N_TRAINS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_TRAINS-1:0] req,
  input  logic                occ,
  output logic [N_TRAINS-1:0] grant,
  output logic [IDW-1:0]      grant_id,
  output logic                busy,
  output logic                fault,
  output logic                timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(CLEAR_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GUARD_LAST = GW'(CLEAR_CYCLES - 1);
  localparam logic [GW-1:0] GUARD_MAX  = GW'(CLEAR_CYCLES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT    = 3'd1,
    OCCUPIED = 3'd2,
    CLEAR    = 3'd3,
    FAULT    = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [IDW-1:0]      last, last_n;
  logic [IDW-1:0]      grant_id_n;
  logic [N_TRAINS-1:0] grant_n;
  logic [TW-1:0]       timer, timer_n;
  logic [GW-1:0]       guard, guard_n;
  logic                busy_n, fault_n, timeout_n;

  logic                pick_found;
  logic [IDW-1:0]      pick_id;
  logic [IDW-1:0]      cand;

  // Round-robin search starting one past the last granted train, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int i = 1; i <= N_TRAINS; i++) begin
      cand = IDW'((int'(last) + i) % N_TRAINS);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    grant_id_n = grant_id;
    last_n     = last;
    timer_n    = timer;
    guard_n    = guard;
    timeout_n  = 1'b0;
    case (state)
      IDLE: begin
        grant_n = '0;
        if (occ) begin
          state_n = FAULT;
        end else if (pick_found) begin
          state_n          = GRANT;
          grant_n[pick_id] = 1'b1;
          grant_id_n       = pick_id;
          last_n           = pick_id;
          timer_n          = '0;
        end
      end
      GRANT: begin
        if (timer != TIMER_MAX) timer_n = timer + TW'(1);
        // Entry beats abandon, and abandon beats expiry in the same cycle.
        if (occ) begin
          state_n = OCCUPIED;
          grant_n = '0;
        end else if (!req[grant_id]) begin
          state_n = CLEAR;
          grant_n = '0;
          guard_n = '0;
        end else if (timer == TIMER_LAST) begin
          state_n   = CLEAR;
          grant_n   = '0;
          guard_n   = '0;
          timeout_n = 1'b1;
        end
      end
      OCCUPIED: begin
        grant_n = '0;
        if (!occ) begin
          state_n = CLEAR;
          guard_n = '0;
        end
      end
      CLEAR: begin
        grant_n = '0;
        if (occ) begin
          state_n = FAULT;
          guard_n = '0;
        end else if (guard == GUARD_LAST) begin
          state_n = IDLE;
        end else if (guard != GUARD_MAX) begin
          guard_n = guard + GW'(1);
        end
      end
      FAULT: begin
        grant_n = '0;
        if (!occ) begin
          state_n = CLEAR;
          guard_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
    busy_n  = (state_n != IDLE);
    fault_n = (state_n == FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= IDW'(N_TRAINS - 1);
      grant    <= '0;
      grant_id <= '0;
      timer    <= '0;
      guard    <= '0;
      busy     <= 1'b0;
      fault    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      last     <= last_n;
      grant    <= grant_n;
      grant_id <= grant_id_n;
      timer    <= timer_n;
      guard    <= guard_n;
      busy     <= busy_n;
      fault    <= fault_n;
      timeout  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_track_junction_arbiter.sv
// Directed bench for track_junction_arbiter: grant, fairness, timeout, abandon,
// fault and reset scenarios with hand-computed expected outputs.
module tb_track_junction_arbiter;

  localparam int N_TRAINS       = 4;
  localparam int CLEAR_CYCLES   = 8;
  localparam int TIMEOUT_CYCLES = 255;
  localparam int IDW            = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_TRAINS-1:0] req;
  logic                occ;
  logic [N_TRAINS-1:0] grant;
  logic [IDW-1:0]      grant_id;
  logic                busy;
  logic                fault;
  logic                timeout;

  int checks = 0;
  int errors = 0;

  track_junction_arbiter #(
    .N_TRAINS       (N_TRAINS),
    .CLEAR_CYCLES   (CLEAR_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .occ      (occ),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .fault    (fault),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_grant"},   32'(grant),    32'h0);
    check({tag, "_busy"},    32'(busy),     32'h0);
    check({tag, "_fault"},   32'(fault),    32'h0);
    check({tag, "_timeout"}, 32'(timeout),  32'h0);
  endtask

  // From the first CLEAR cycle: the remaining guard cycles, then IDLE.
  task automatic finish_clear(input string tag);
    for (int i = 1; i < CLEAR_CYCLES; i++) begin
      tick();
      check({tag, "_clear_busy"}, 32'(busy), 32'h1);
    end
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    req = '0;
    occ = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle_outputs("reset");
    check("reset_grant_id", 32'(grant_id), 32'h0);

    // Single request, entry, exit and guard interval.
    req = 4'b0100;
    tick();
    check("single_grant",    32'(grant),    32'h4);
    check("single_grant_id", 32'(grant_id), 32'h2);
    check("single_busy",     32'(busy),     32'h1);
    occ = 1'b1;
    req = 4'b0000;
    tick();
    check("single_entry_grant", 32'(grant), 32'h0);
    tick();
    check("single_occ_busy", 32'(busy), 32'h1);
    occ = 1'b0;
    tick();
    check("single_clear1_busy", 32'(busy), 32'h1);
    finish_clear("single");

    // Fairness from a fresh reset with all four trains requesting.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("reset2");
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      check($sformatf("fair%0d_grant", n),    32'(grant),    32'(1) << order[n]);
      check($sformatf("fair%0d_grant_id", n), 32'(grant_id), 32'(order[n]));
      occ = 1'b1;
      tick();
      occ = 1'b0;
      tick();
      finish_clear($sformatf("fair%0d", n));
    end
    req = 4'b0000;

    // Timeout: train 1 alone, never enters.
    req = 4'b0010;
    tick();
    check("to_grant_first", 32'(grant), 32'h2);
    repeat (TIMEOUT_CYCLES - 1) tick();
    check("to_grant_last",   32'(grant),   32'h2);
    check("to_timeout_last", 32'(timeout), 32'h0);
    tick();
    check("to_grant_off", 32'(grant),   32'h0);
    check("to_pulse",     32'(timeout), 32'h1);
    check("to_busy",      32'(busy),    32'h1);
    check("to_no_fault",  32'(fault),   32'h0);
    tick();
    check("to_pulse_end", 32'(timeout), 32'h0);
    repeat (CLEAR_CYCLES - 2) tick();
    check("to_clear_last_busy",  32'(busy),  32'h1);
    check("to_clear_last_grant", 32'(grant), 32'h0);
    tick();
    check("to_idle_busy", 32'(busy), 32'h0);
    tick();
    check("to_regrant",    32'(grant),    32'h2);
    check("to_regrant_id", 32'(grant_id), 32'h1);

    // Abandon: request drops while granted.
    req = 4'b0000;
    tick();
    check("abandon_grant",   32'(grant),   32'h0);
    check("abandon_timeout", 32'(timeout), 32'h0);
    check("abandon_busy",    32'(busy),    32'h1);
    finish_clear("abandon");

    // Request drop and entry in the same cycle: entry wins.
    req = 4'b0100;
    tick();
    check("race_grant", 32'(grant), 32'h4);
    req = 4'b0000;
    occ = 1'b1;
    tick();
    check("race_grant_off", 32'(grant),   32'h0);
    check("race_timeout",   32'(timeout), 32'h0);
    tick();
    tick();
    check("race_occupied_fault", 32'(fault), 32'h0);
    check("race_occupied_busy",  32'(busy),  32'h1);
    occ = 1'b0;
    tick();
    finish_clear("race");

    // Unauthorized occupancy in IDLE outranks a pending request.
    req = 4'b0001;
    occ = 1'b1;
    tick();
    check("fault_idle_fault", 32'(fault), 32'h1);
    check("fault_idle_grant", 32'(grant), 32'h0);
    check("fault_idle_busy",  32'(busy),  32'h1);
    occ = 1'b0;
    tick();
    check("fault_clear_fault", 32'(fault), 32'h0);
    tick();
    occ = 1'b1;
    tick();
    check("fault_in_clear", 32'(fault), 32'h1);
    check("fault_in_clear_grant", 32'(grant), 32'h0);
    occ = 1'b0;
    tick();
    check("fault_release", 32'(fault), 32'h0);
    finish_clear("fault");
    tick();
    check("fault_regrant",    32'(grant),    32'h1);
    check("fault_regrant_id", 32'(grant_id), 32'h0);

    // Reset while occupied, then round-robin restarts at train 0.
    occ = 1'b1;
    tick();
    check("mid_occupied_grant", 32'(grant), 32'h0);
    rst = 1'b1;
    tick();
    check_idle_outputs("mid_reset");
    check("mid_reset_grant_id", 32'(grant_id), 32'h0);
    rst = 1'b0;
    occ = 1'b0;
    req = 4'b1111;
    tick();
    check("post_reset_grant",    32'(grant),    32'h1);
    check("post_reset_grant_id", 32'(grant_id), 32'h0);

    // Entry sampled in the final grant cycle beats the timeout.
    repeat (TIMEOUT_CYCLES - 1) tick();
    check("late_entry_grant", 32'(grant), 32'h1);
    occ = 1'b1;
    tick();
    check("late_entry_grant_off", 32'(grant),   32'h0);
    check("late_entry_timeout",   32'(timeout), 32'h0);
    check("late_entry_busy",      32'(busy),    32'h1);
    tick();
    check("late_entry_fault", 32'(fault), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
